// File: rtl/pic_ack_sequencer.sv
// CPU-side strobe sequencer for a cascaded 8259-style PIC array: runs the two-pulse
// INTA cycle, captures the vector, optionally writes a non-specific EOI, and serializes host writes.
module pic_ack_sequencer #(
    parameter int         PULSE_W  = 2,
    parameter int         GAP_W    = 2,
    parameter bit         AUTO_EOI = 1'b1,
    parameter logic [7:0] EOI_CMD  = 8'h20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       INT,
    input  logic       ack_en,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_a0,
    input  logic [7:0] cmd_data,
    output logic       INTA,
    output logic       WR,
    output logic       RD,
    output logic       CS,
    output logic       A0,
    output logic [7:0] D_out,
    output logic       D_oe,
    input  logic [7:0] D_in,
    output logic [7:0] vector,
    output logic       vector_valid,
    output logic       busy
);

    localparam int CNT_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W - 1);
    localparam logic [CNT_W-1:0] ONE_LD   = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INTA1_LO,
        S_INTA1_HI,
        S_INTA2_LO,
        S_VEC_DONE,
        S_WR_SETUP,
        S_WR_LO,
        S_WR_HOLD
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_int_meta;
    logic             r_int_s;
    logic             r_lat_a0;
    logic [7:0]       r_lat_data;
    logic             w_lat_a0_nxt;
    logic [7:0]       w_lat_data_nxt;
    logic             w_capture;
    logic             w_pend;
    logic             w_cnt_done;
    logic             w_wr_phase;

    logic             r_inta;
    logic             r_wr;
    logic             r_cs;
    logic             r_a0;
    logic [7:0]       r_d_out;
    logic             r_d_oe;
    logic [7:0]       r_vector;
    logic             r_vec_valid;
    logic             r_busy;

    // INT comes straight from the PIC pin and is unrelated to clk.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int_meta <= 1'b0;
            r_int_s    <= 1'b0;
        end else begin
            r_int_meta <= INT;
            r_int_s    <= r_int_meta;
        end
    end

    assign w_pend     = r_int_s && ack_en;
    assign w_cnt_done = (r_cnt == '0);
    // Gated by rst_n so the host never sees a ready handshake while the block is held in reset.
    assign cmd_ready  = rst_n && (r_state == S_IDLE) && !w_pend;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt - CNT_W'(1);
        w_lat_a0_nxt   = r_lat_a0;
        w_lat_data_nxt = r_lat_data;
        w_capture      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = ONE_LD;
                if (w_pend) begin
                    w_state_nxt = S_INTA1_LO;
                    w_cnt_nxt   = PULSE_LD;
                end else if (cmd_valid) begin
                    w_state_nxt    = S_WR_SETUP;
                    w_lat_a0_nxt   = cmd_a0;
                    w_lat_data_nxt = cmd_data;
                end
            end
            S_INTA1_LO: begin
                if (w_cnt_done) begin
                    w_state_nxt = S_INTA1_HI;
                    w_cnt_nxt   = GAP_LD;
                end
            end
            S_INTA1_HI: begin
                if (w_cnt_done) begin
                    w_state_nxt = S_INTA2_LO;
                    w_cnt_nxt   = PULSE_LD;
                end
            end
            S_INTA2_LO: begin
                if (w_cnt_done) begin
                    w_state_nxt = S_VEC_DONE;
                    w_cnt_nxt   = ONE_LD;
                    w_capture   = 1'b1;
                end
            end
            S_VEC_DONE: begin
                w_cnt_nxt = ONE_LD;
                if (AUTO_EOI) begin
                    w_state_nxt    = S_WR_SETUP;
                    w_lat_a0_nxt   = 1'b0;
                    w_lat_data_nxt = EOI_CMD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WR_SETUP: begin
                w_state_nxt = S_WR_LO;
                w_cnt_nxt   = PULSE_LD;
            end
            S_WR_LO: begin
                if (w_cnt_done) begin
                    w_state_nxt = S_WR_HOLD;
                    w_cnt_nxt   = ONE_LD;
                end
            end
            S_WR_HOLD: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = ONE_LD;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = ONE_LD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_lat_a0   <= 1'b1;
            r_lat_data <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_lat_a0   <= w_lat_a0_nxt;
            r_lat_data <= w_lat_data_nxt;
        end
    end

    // Strobes are decoded from the next state and registered, so the pins never glitch.
    assign w_wr_phase = (w_state_nxt == S_WR_SETUP) || (w_state_nxt == S_WR_LO) ||
                        (w_state_nxt == S_WR_HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inta      <= 1'b1;
            r_wr        <= 1'b1;
            r_cs        <= 1'b1;
            r_a0        <= 1'b1;
            r_d_out     <= 8'h00;
            r_d_oe      <= 1'b0;
            r_vector    <= 8'h00;
            r_vec_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_inta      <= !((w_state_nxt == S_INTA1_LO) || (w_state_nxt == S_INTA2_LO));
            r_wr        <= (w_state_nxt != S_WR_LO);
            r_cs        <= !w_wr_phase;
            r_a0        <= w_wr_phase ? w_lat_a0_nxt : 1'b1;
            r_d_out     <= w_wr_phase ? w_lat_data_nxt : 8'h00;
            r_d_oe      <= w_wr_phase;
            r_vec_valid <= (w_state_nxt == S_VEC_DONE);
            r_busy      <= (w_state_nxt != S_IDLE);
            if (w_capture) begin
                r_vector <= D_in;
            end
        end
    end

    assign INTA         = r_inta;
    assign WR           = r_wr;
    assign RD           = 1'b1;
    assign CS           = r_cs;
    assign A0           = r_a0;
    assign D_out        = r_d_out;
    assign D_oe         = r_d_oe;
    assign vector       = r_vector;
    assign vector_valid = r_vec_valid;
    assign busy         = r_busy;

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Randomized scoreboard bench: a PIC/host model issues traffic and queues expected bus
// transactions; a negedge monitor decodes the strobes and checks them in order.
module tb_pic_ack_sequencer;

    localparam int         PULSE_W = 2;
    localparam int         GAP_W   = 2;
    localparam logic [7:0] EOI     = 8'h20;

    typedef struct packed {
        logic       is_vec;
        logic       a0;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic INT, ack_en, cmd_valid, cmd_ready, cmd_a0;
    logic [7:0] cmd_data, D_out, D_in, vector;
    logic INTA, WR, RD, CS, A0, D_oe, vector_valid, busy;

    logic n_INT, n_ack_en, n_cmd_valid, n_cmd_ready, n_cmd_a0;
    logic [7:0] n_cmd_data, n_D_out, n_D_in, n_vector;
    logic n_INTA, n_WR, n_RD, n_CS, n_A0, n_D_oe, n_vector_valid, n_busy;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pic_ack_sequencer #(.PULSE_W(PULSE_W), .GAP_W(GAP_W), .AUTO_EOI(1'b1), .EOI_CMD(EOI)) dut (
        .clk(clk), .rst_n(rst_n), .INT(INT), .ack_en(ack_en),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a0(cmd_a0), .cmd_data(cmd_data),
        .INTA(INTA), .WR(WR), .RD(RD), .CS(CS), .A0(A0), .D_out(D_out), .D_oe(D_oe),
        .D_in(D_in), .vector(vector), .vector_valid(vector_valid), .busy(busy)
    );

    pic_ack_sequencer #(.PULSE_W(PULSE_W), .GAP_W(GAP_W), .AUTO_EOI(1'b0), .EOI_CMD(EOI)) dut_ne (
        .clk(clk), .rst_n(rst_n), .INT(n_INT), .ack_en(n_ack_en),
        .cmd_valid(n_cmd_valid), .cmd_ready(n_cmd_ready), .cmd_a0(n_cmd_a0), .cmd_data(n_cmd_data),
        .INTA(n_INTA), .WR(n_WR), .RD(n_RD), .CS(n_CS), .A0(n_A0), .D_out(n_D_out), .D_oe(n_D_oe),
        .D_in(n_D_in), .vector(n_vector), .vector_valid(n_vector_valid), .busy(n_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic is_vec, input logic a0, input logic [7:0] data);
        exp_t e;
        e.is_vec = is_vec;
        e.a0     = a0;
        e.data   = data;
        exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    logic       m_prev_inta, m_prev_cs, m_prev_wr, m_a0, m_vv_exp;
    logic [7:0] m_d;
    int         m_lo, m_hi, m_pulse, m_cs_len, m_wr_lo;
    exp_t       m_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_prev_inta = 1'b1; m_prev_cs = 1'b1; m_prev_wr = 1'b1;
            m_lo = 0; m_hi = 0; m_pulse = 0; m_cs_len = 0; m_wr_lo = 0;
        end else begin
            check("rd_high", RD, 1'b1);
            check("doe_vs_cs", D_oe, !CS);
            check("no_drive_in_inta", (INTA || !D_oe), 1'b1);

            m_vv_exp = !m_prev_inta && INTA && (m_pulse == 1);
            if (!INTA) begin
                if (m_prev_inta) begin
                    if (m_pulse == 1) check("inta_gap", m_hi, GAP_W);
                    m_lo = 0;
                end
                m_lo++;
            end else if (!m_prev_inta) begin
                check("inta_width", m_lo, PULSE_W);
                if (m_pulse == 1) m_pulse = 0;
                else begin m_pulse = 1; m_hi = 1; end
            end else if (m_pulse == 1) begin
                m_hi++;
            end

            if (vector_valid || m_vv_exp) begin
                check("vector_valid", vector_valid, m_vv_exp);
                if (m_vv_exp) begin
                    check("vec_expected", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        m_e = exp_q.pop_front();
                        check("vec_kind", m_e.is_vec, 1'b1);
                        check("vector", vector, m_e.data);
                    end
                end
            end

            if (!CS) begin
                if (m_prev_cs) begin
                    m_cs_len = 0; m_wr_lo = 0; m_a0 = A0; m_d = D_out;
                    check("wr_setup", WR, 1'b1);
                end
                m_cs_len++;
                if (!WR) m_wr_lo++;
                check("a0_stable", A0, m_a0);
                check("dout_stable", D_out, m_d);
            end else begin
                check("wr_outside_cs", WR, 1'b1);
                if (!m_prev_cs) begin
                    check("wr_hold", m_prev_wr, 1'b1);
                    check("cs_len", m_cs_len, PULSE_W + 2);
                    check("wr_width", m_wr_lo, PULSE_W);
                    check("wr_expected", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        m_e = exp_q.pop_front();
                        check("wr_kind", m_e.is_vec, 1'b0);
                        check("wr_a0", m_a0, m_e.a0);
                        check("wr_data", m_d, m_e.data);
                    end
                end
            end
            m_prev_inta = INTA; m_prev_cs = CS; m_prev_wr = WR;
        end
    end

    // ---------------- stimulus helpers (entered at a negedge) ----------------
    task automatic wait_inta(input logic lvl, output int n);
        bit seen = 0;
        n = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (INTA === lvl) seen = 1;
        end
        check("inta_wait", seen, 1'b1);
    endtask

    task automatic wait_cs(input logic lvl);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (CS === lvl) seen = 1;
        end
        check("cs_wait", seen, 1'b1);
    endtask

    task automatic wait_idle();
        bit seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (busy === 1'b0) seen = 1;
        end
        check("idle_wait", seen, 1'b1);
    endtask

    // PIC model: the vector is presented only in the capture cycle so off-by-one sampling shows up.
    task automatic serve_ack(input logic [7:0] vec, input bit drop_early, input bit drop_late,
                             output int lat);
        int n;
        D_in = ~vec;
        wait_inta(1'b0, lat);
        if (drop_early) INT = 1'b0;
        wait_inta(1'b1, n);
        wait_inta(1'b0, n);
        for (int lo = 1; lo < PULSE_W; lo++) @(negedge clk);
        D_in = vec;
        @(negedge clk);
        D_in = ~vec;
        if (drop_late) INT = 1'b0;
    endtask

    task automatic do_cmd(input logic a0, input logic [7:0] data);
        bit acc = 0;
        cmd_valid = 1'b1; cmd_a0 = a0; cmd_data = data;
        for (int i = 0; i < 60 && !acc; i++) begin
            if (cmd_ready === 1'b1) begin
                acc = 1;
                push_exp(1'b0, a0, data);
            end else begin
                @(negedge clk);
            end
        end
        check("cmd_accept", acc, 1'b1);
        if (acc) begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0; cmd_a0 = 1'($urandom); cmd_data = 8'($urandom);
            for (int k = 1; k <= PULSE_W + 3; k++) begin
                @(negedge clk);
                if (k <= PULSE_W + 2) begin
                    check("wr_cs_low", CS, 1'b0);
                    check("wr_doe", D_oe, 1'b1);
                    check("wr_dout", D_out, data);
                    check("wr_a0_pin", A0, a0);
                end else begin
                    check("wr_done_cs", CS, 1'b1);
                    check("wr_done_ready", cmd_ready, 1'b1);
                end
                check("wr_strobe", WR, (k >= 2 && k <= PULSE_W + 1) ? 1'b0 : 1'b1);
            end
        end else begin
            cmd_valid = 1'b0;
        end
    endtask

    task automatic do_irq(input logic [7:0] vec, input bit spurious);
        int lat;
        push_exp(1'b1, 1'b0, vec);
        push_exp(1'b0, 1'b0, EOI);
        INT = 1'b1;
        serve_ack(vec, spurious, !spurious, lat);
        check("int_to_inta_latency", lat, 3);
        wait_idle();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat, lows;
        bit seen, wr_seen, cs_seen;
        rst_n = 1'b0; INT = 1'b0; ack_en = 1'b1; cmd_valid = 1'b0; cmd_a0 = 1'b0;
        cmd_data = 8'h00; D_in = 8'h00;
        n_INT = 1'b0; n_ack_en = 1'b1; n_cmd_valid = 1'b0; n_cmd_a0 = 1'b0;
        n_cmd_data = 8'h00; n_D_in = 8'h5A;
        #12;
        check("rst_inta", INTA, 1'b1);    check("rst_wr", WR, 1'b1);
        check("rst_cs", CS, 1'b1);        check("rst_a0", A0, 1'b1);
        check("rst_doe", D_oe, 1'b0);     check("rst_dout", D_out, 8'h00);
        check("rst_vector", vector, 8'h00); check("rst_vv", vector_valid, 1'b0);
        check("rst_busy", busy, 1'b0);    check("rst_ready", cmd_ready, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_cmd(1'b0, 8'h11);
        do_irq(8'h08, 1'b0);

        // Arbitration: interrupt pending when the write request shows up.
        push_exp(1'b1, 1'b0, 8'h33);
        push_exp(1'b0, 1'b0, EOI);
        INT = 1'b1;
        repeat (2) @(negedge clk);
        check("arb_ready_low", cmd_ready, 1'b0);
        fork
            serve_ack(8'h33, 1'b0, 1'b1, lat);
            do_cmd(1'b0, 8'h0A);
        join
        wait_idle();

        do_irq(8'h0F, 1'b1);

        // Back-to-back: INT held across two acknowledges.
        push_exp(1'b1, 1'b0, 8'h41); push_exp(1'b0, 1'b0, EOI);
        push_exp(1'b1, 1'b0, 8'h42); push_exp(1'b0, 1'b0, EOI);
        INT = 1'b1;
        serve_ack(8'h41, 1'b0, 1'b0, lat);
        wait_cs(1'b0);
        wait_cs(1'b1);
        serve_ack(8'h42, 1'b1, 1'b0, lat);
        check("b2b_min_gap", lat, 1);
        wait_idle();

        // Masking: no acknowledge while ack_en=0, host writes still flow.
        ack_en = 1'b0;
        INT = 1'b1;
        repeat (3) @(negedge clk);
        check("mask_ready", cmd_ready, 1'b1);
        do_cmd(1'b1, 8'hC5);
        lows = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!INTA) lows++;
        end
        check("mask_no_inta", lows, 0);
        INT = 1'b0;
        repeat (3) @(negedge clk);
        ack_en = 1'b1;
        @(negedge clk);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0, 1:    do_cmd(1'($urandom), 8'($urandom));
                2:       do_irq(8'($urandom), 1'b0);
                default: do_irq(8'h0F, 1'b1);
            endcase
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // AUTO_EOI=0 instance: vector captured, no write follows.
        n_INT = 1'b1;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (n_INTA === 1'b0) seen = 1;
        end
        check("ne_inta_seen", seen, 1'b1);
        n_INT = 1'b0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            check("ne_no_drive", n_D_oe, 1'b0);
            if (n_vector_valid === 1'b1) seen = 1;
        end
        check("ne_vv_seen", seen, 1'b1);
        check("ne_vector", n_vector, 8'h5A);
        wr_seen = 0; cs_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) check("ne_idle_after_vec", n_busy, 1'b0);
            if (!n_WR) wr_seen = 1;
            if (!n_CS) cs_seen = 1;
        end
        check("ne_no_wr", wr_seen, 1'b0);
        check("ne_no_cs", cs_seen, 1'b0);
        check("ne_rd", n_RD, 1'b1);
        check("ne_ready", n_cmd_ready, 1'b1);

        // Reset in the middle of INTA1_LO.
        INT = 1'b1;
        wait_inta(1'b0, lat);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_inta", INTA, 1'b1);
        check("midrst_doe", D_oe, 1'b0);
        check("midrst_vector", vector, 8'h00);
        check("midrst_busy", busy, 1'b0);
        INT = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("postrst_busy", busy, 1'b0);
        check("postrst_inta", INTA, 1'b1);
        check("postrst_ready", cmd_ready, 1'b1);

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_vec);
        $fatal(1);
    end

endmodule

// File: doc/pic_ack_sequencer.md
Name: pic_ack_sequencer

Overview:
CPU-side bus controller for the cascaded PIC array (master plus up to seven slaves on a shared D bus).
- Owns the shared control strobes INTA, WR, RD, CS and A0 for the master PIC.
- On INT from the master, runs the two-pulse INTA cycle and captures the vector from D.
- Optionally issues an automatic non-specific EOI (OCW2) afterwards.
- Arbitrates host register-write commands (ICW/OCW programming) against interrupt acknowledge, so the bus sees exactly one transaction at a time.

Parameters:
PULSE_W, 2, cycles each INTA/WR strobe is held low (>=1)
GAP_W, 2, cycles INTA held high between the two INTA pulses (>=1)
AUTO_EOI, 1, 1 = issue OCW2 write after every vector capture
EOI_CMD, 8'h20, OCW2 byte written on auto EOI (A0=0)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
INT  in  1  master PIC interrupt output, asynchronous, synchronized internally
ack_en  in  1  1 = interrupts may be acknowledged
cmd_valid  in  1  host write request
cmd_ready  out  1  request accepted when cmd_valid && cmd_ready
cmd_a0  in  1  A0 value for the write
cmd_data  in  8  byte to write
INTA  out  1  active-low interrupt acknowledge to all PICs
WR  out  1  active-low write strobe to master PIC
RD  out  1  active-low read strobe, held high (reserved)
CS  out  1  active-low chip select to master PIC
A0  out  1  address line
D_out  out  8  data driven onto D
D_oe  out  1  1 = drive D_out onto D, else tri-state
D_in  in  8  sampled D bus
vector  out  8  last captured vector, held until next capture
vector_valid  out  1  one-cycle pulse when vector updates
busy  out  1  1 whenever state != IDLE

Behaviour:
Reset values (async, immediate):
- INTA=WR=RD=CS=1, A0=1, D_oe=0, D_out=0, vector=0, vector_valid=0, busy=0, cmd_ready=0, state=IDLE, synchronizer cleared.

INT synchronization:
- Two-flop synchronizer produces int_s.
- A pending acknowledge is int_s && ack_en, evaluated in IDLE only.

cmd_ready:
- Equals (state==IDLE) && !(int_s && ack_en).
- Interrupt acknowledge has strict priority over host writes.

State machine (counter cnt reloads on every transition):
- IDLE: if pending ack -> INTA1_LO. Else if cmd_valid && cmd_ready -> latch cmd_a0/cmd_data -> WR_SETUP.
- INTA1_LO: INTA=0 for PULSE_W cycles -> INTA1_HI.
- INTA1_HI: INTA=1 for GAP_W cycles -> INTA2_LO.
- INTA2_LO: INTA=0 for PULSE_W cycles. D_in is sampled into the vector register on the last low cycle. -> VEC_DONE.
- VEC_DONE (1 cycle): INTA=1, vector_valid=1. If AUTO_EOI, latch A0=0 and data=EOI_CMD -> WR_SETUP; else -> IDLE.
- WR_SETUP (1 cycle): CS=0, A0=latched value, D_out=latched data, D_oe=1, WR=1.
- WR_LO: WR=0, CS=0, D_oe=1 for PULSE_W cycles.
- WR_HOLD (1 cycle): WR=1, CS=0, D_oe=1 (data hold after rising WR) -> IDLE, where CS=1 and D_oe=0.

INTA cycle rules:
- The cycle is never aborted. If INT drops after INTA1 starts, both pulses still complete and D is captured (spurious IR7 vector from the PIC is passed through).
- D_oe=0 throughout the INTA cycle; the PICs own D.
- A cmd_valid arriving mid-sequence waits; it is not dropped and not accepted until IDLE.

Latency:
- IDLE with int_s=1 at cycle t: INTA low t+1..t+PULSE_W, then gap, then INTA2.
- vector_valid fires the cycle after the INTA2 rising edge.
- Default parameters: vector_valid at t+7, with INT-to-int_s adding 2 cycles.
- Host write, accept at t: WR low t+2..t+1+PULSE_W, back in IDLE at t+3+PULSE_W.

Reset mid-operation:
- All strobes return high and D_oe=0 asynchronously.
- Any latched command is discarded; vector is cleared.

Back-to-back interrupts:
- After auto EOI, IDLE re-evaluates int_s in the same cycle it is entered.
- The minimum gap between two INTA cycles is one IDLE cycle.

Test Plan:
- Reset: rst_n low mid-INTA1_LO -> INTA=1, D_oe=0, vector=0 same cycle; busy=0 after release.
- Host write: cmd_a0=0, cmd_data=8'h11 accepted at t -> CS=0 from t+1, WR=0 t+2..t+3, D_out=8'h11 with D_oe=1 t+1..t+4, cmd_ready back high t+5.
- Acknowledge: INT rises, D_in=8'h08 during INTA2 -> exactly two INTA pulses of 2 cycles each, 2-cycle gap; vector=8'h08; one vector_valid pulse; then auto EOI write with A0=0, D_out=8'h20.
- Arbitration: cmd_valid and INT both asserted while in IDLE -> INTA cycle runs first; the write (data 8'h0A) follows the EOI write; cmd_ready stays 0 throughout.
- Spurious interrupt: INT drops after first INTA falls, D_in=8'h0F -> second pulse still issued; vector=8'h0F.
- Masking and AUTO_EOI=0: ack_en=0 with INT=1 -> no INTA, and host writes are still accepted. With AUTO_EOI=0, no WR pulse follows VEC_DONE.
